// File: rtl/slib_uart_tx_serializer.sv
// UART transmit serializer: start bit, 5..8 data bits LSB first, optional parity,
// then 1 / 1.5 / 2 stop bits, timed by an OVERSAMPLE x baud clock enable.
// Optional feature macro: SLIB_UART_TX_BREAK_EN (break control forces TXD low).
module slib_uart_tx_serializer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       start_i,
    input  logic [7:0] din_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sp_i,
    input  logic       bc_i,
    output logic       txd_o,
    output logic       busy_o,
    output logic       finished_o
);

    // Wide enough for the longest state (two stop bits).
    localparam int unsigned TickW = $clog2(2 * OVERSAMPLE);
    localparam logic [TickW-1:0] BitLast    = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] StopLast15 = TickW'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [TickW-1:0] StopLast2  = TickW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;

    // Frame settings captured when a character is accepted.
    logic [7:0] data_q;
    logic [1:0] wls_q;
    logic       stb_q;
    logic       pen_q;
    logic       eps_q;
    logic       sp_q;

    logic             accept;
    logic [7:0]       word_mask;
    logic [2:0]       last_bit;
    logic [2:0]       bit_nxt;
    logic             par_bit;
    logic [TickW-1:0] stop_last;
    logic [TickW-1:0] tick_last;
    logic             adv;

    assign accept    = (state_q == StIdle) && start_i;
    assign word_mask = 8'hFF >> (2'd3 - wls_i);
    assign last_bit  = 3'd4 + {1'b0, wls_q};
    assign bit_nxt   = bit_q + 3'd1;
    // Bits above the word length are zero in data_q, so a full XOR is safe.
    assign par_bit   = sp_q ? ~eps_q : (eps_q ? ^data_q : ~(^data_q));
    assign stop_last = !stb_q ? BitLast : ((wls_q == 2'b00) ? StopLast15 : StopLast2);
    assign tick_last = (state_q == StStop) ? stop_last : BitLast;

    // Capture the character and line settings on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 8'h00;
            wls_q  <= 2'b00;
            stb_q  <= 1'b0;
            pen_q  <= 1'b0;
            eps_q  <= 1'b0;
            sp_q   <= 1'b0;
        end else if (accept) begin
            data_q <= din_i & word_mask;
            wls_q  <= wls_i;
            stb_q  <= stb_i;
            pen_q  <= pen_i;
            eps_q  <= eps_i;
            sp_q   <= sp_i;
        end
    end

    // Next-state, tick/bit counters and next line level.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        line_d  = line_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        adv     = 1'b0;

        if (state_q != StIdle && ce_i) begin
            if (tick_q == tick_last) begin
                adv    = 1'b1;
                tick_d = '0;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StStart;
                    tick_d  = '0;
                    bit_d   = '0;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (adv) begin
                    state_d = StData;
                    bit_d   = '0;
                    line_d  = data_q[0];
                end
            end
            StData: begin
                if (adv) begin
                    if (bit_q == last_bit) begin
                        if (pen_q) begin
                            state_d = StParity;
                            line_d  = par_bit;
                        end else begin
                            state_d = StStop;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_nxt;
                        line_d = data_q[bit_nxt];
                    end
                end
            end
            StParity: begin
                if (adv) begin
                    state_d = StStop;
                    line_d  = 1'b1;
                end
            end
            StStop: begin
                if (adv) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    line_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
                bit_d   = '0;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign busy_o     = busy_q;
    assign finished_o = fin_q;

`ifdef SLIB_UART_TX_BREAK_EN
    logic txd_q;

    // Break overrides the line level only; the FSM keeps its timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txd_q <= 1'b1;
        end else begin
            txd_q <= bc_i ? 1'b0 : line_d;
        end
    end

    assign txd_o = txd_q;
`else
    logic unused_bc;
    assign unused_bc = bc_i;
    assign txd_o     = line_q;
`endif

endmodule
